data_mem_lsu: RTL

DATA_MEM_LSU -- requirements
Module: data_mem_lsu

---
 rtl/data_mem_lsu.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_lsu.sv
// Word-organised data memory with an RV32I load/store front end (IDLE -> ACCESS -> RESP).
// Define DMEM_MISALIGN_CHK_EN to fault misaligned halfword/word accesses.
module data_mem_lsu #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic              we_r;
  logic [2:0]        funct3_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;

  logic [31:0]       mem [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic [31:0]       word;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic              mis_h;
  logic              mis_w;
  logic              out_of_range;
  logic              acc_err;
  logic [31:0]       load_data;
  logic [3:0]        wmask;
  logic [31:0]       wword;

  assign idx  = addr_r[IDX_W+1:2];
  assign word = mem[idx];

`ifdef DMEM_MISALIGN_CHK_EN
  assign mis_h = addr_r[0];
  assign mis_w = |addr_r[1:0];
`else
  assign mis_h = 1'b0;
  assign mis_w = 1'b0;
`endif

  always_comb begin
    case (addr_r[1:0])
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr_r[1] ? word[31:16] : word[15:0];
  end

  // Decode the captured request into a lane write mask, a load result and a fault flag;
  // any fault suppresses both the write and the load data.
  always_comb begin
    acc_err      = 1'b0;
    load_data    = 32'd0;
    wmask        = 4'b0000;
    wword        = 32'd0;
    out_of_range = (addr_r >> (IDX_W + 2)) != '0;
    if (we_r) begin
      case (funct3_r)
        3'b000: begin
          wmask = 4'b0001 << addr_r[1:0];
          wword = {4{wdata_r[7:0]}};
        end
        3'b001: begin
          acc_err = mis_h;
          wmask   = addr_r[1] ? 4'b1100 : 4'b0011;
          wword   = {2{wdata_r[15:0]}};
        end
        3'b010: begin
          acc_err = mis_w;
          wmask   = 4'b1111;
          wword   = wdata_r;
        end
        default: acc_err = 1'b1;
      endcase
    end else begin
      case (funct3_r)
        3'b000: load_data = {{24{byte_sel[7]}}, byte_sel};
        3'b001: begin
          acc_err   = mis_h;
          load_data = {{16{half_sel[15]}}, half_sel};
        end
        3'b010: begin
          acc_err   = mis_w;
          load_data = word;
        end
        3'b100: load_data = {24'd0, byte_sel};
        3'b101: begin
          acc_err   = mis_h;
          load_data = {16'd0, half_sel};
        end
        default: acc_err = 1'b1;
      endcase
    end
    if (out_of_range) begin
      acc_err = 1'b1;
    end
    if (acc_err) begin
      wmask     = 4'b0000;
      load_data = 32'd0;
    end
  end

  // Memory has no reset; an asynchronous reset during ACCESS drops state to IDLE first.
  always_ff @(posedge clk) begin
    if (state == ACCESS) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) begin
          mem[idx][8*i +: 8] <= wword[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      we_r      <= 1'b0;
      funct3_r  <= 3'd0;
      addr_r    <= '0;
      wdata_r   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            we_r      <= req_we;
            funct3_r  <= req_funct3;
            addr_r    <= req_addr;
            wdata_r   <= req_wdata;
            req_ready <= 1'b0;
            state     <= ACCESS;
          end else begin
            req_ready <= 1'b1;
          end
        end
        ACCESS: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= load_data;
          rsp_err   <= acc_err;
          state     <= RESP;
        end
        RESP: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
